// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions.
//   DataBus / DataAddrBus : core data and address bus widths
//   IndexMax              : widest word index a buffer entry can hold
//   SEL_WORD              : all four byte lanes enabled
//   wbuf_entry_t          : one posted-write buffer entry
package mem_pkg;

    localparam int unsigned DataBus     = 32;
    localparam int unsigned DataAddrBus = 32;
    localparam int unsigned IndexMax    = DataAddrBus - 2;

    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef struct packed {
        logic [IndexMax-1:0] index;
        logic [3:0]          sel;
        logic [DataBus-1:0]  data;
        logic                valid;
    } wbuf_entry_t;

endpackage

// File: rtl/data_ram_if.sv
// Core-side data memory bus (the core's ram_* signals).
//   ce, we, addr, sel, wdata : request from the core
//   rdata                    : combinational read data back to the core
//   stall                    : write buffer full; core writes are dropped
// Modports: master = core, slave = memory.
interface data_ram_if;
    import mem_pkg::*;

    logic                   ce;
    logic                   we;
    logic [DataAddrBus-1:0] addr;
    logic [3:0]             sel;
    logic [DataBus-1:0]     wdata;
    logic [DataBus-1:0]     rdata;
    logic                   stall;

    modport master (
        output ce, we, addr, sel, wdata,
        input  rdata, stall
    );

    modport slave (
        input  ce, we, addr, sel, wdata,
        output rdata, stall
    );

endinterface

// File: rtl/data_ram_wbuf.sv
// Posted-write buffer for data_ram.
//   clk, rst                      : clock, async active-low reset
//   push_req_i/index/sel/data     : core write request (dropped when stall_o is set)
//   drain_block_i                 : loader owns the array write port this cycle
//   drain_o/index/sel/data        : head entry being written to the array this edge
//   rd_index_i                    : word index being read
//   hit_o, fwd_data_o             : per-lane newest matching entry data
//   stall_o                       : registered buffer-full flag
module data_ram_wbuf
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WBUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_req_i,
    input  logic [ADDR_WIDTH-1:0] push_index_i,
    input  logic [3:0]            push_sel_i,
    input  logic [DataBus-1:0]    push_data_i,
    input  logic                  drain_block_i,
    output logic                  drain_o,
    output logic [ADDR_WIDTH-1:0] drain_index_o,
    output logic [3:0]            drain_sel_o,
    output logic [DataBus-1:0]    drain_data_o,
    input  logic [ADDR_WIDTH-1:0] rd_index_i,
    output logic [3:0]            hit_o,
    output logic [DataBus-1:0]    fwd_data_o,
    output logic                  stall_o
);

    localparam int unsigned PtrW = $clog2(WBUF_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    wbuf_entry_t     entries_q [WBUF_DEPTH];
    logic [PtrW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q, count_d;
    logic            stall_q;
    logic            push, pop;

    // stall_q mirrors "full", so a write seen while full is rejected even if
    // the head drains on the same edge.
    assign push = push_req_i & ~stall_q;
    assign pop  = entries_q[head_q].valid & ~drain_block_i;

    assign drain_o       = pop;
    assign drain_index_o = entries_q[head_q].index[ADDR_WIDTH-1:0];
    assign drain_sel_o   = entries_q[head_q].sel;
    assign drain_data_o  = entries_q[head_q].data;
    assign stall_o       = stall_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
            for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + PtrW'(1);
            end
            if (push) begin
                entries_q[tail_q].index <= IndexMax'(push_index_i);
                entries_q[tail_q].sel   <= push_sel_i;
                entries_q[tail_q].data  <= push_data_i;
                entries_q[tail_q].valid <= 1'b1;
                tail_q                  <= tail_q + PtrW'(1);
            end
            count_q <= count_d;
            stall_q <= (count_d == CntW'(WBUF_DEPTH));
        end
    end

    // Walk oldest to newest so later matches overwrite earlier ones per lane.
    always_comb begin
        hit_o      = '0;
        fwd_data_o = '0;
        for (int k = 0; k < int'(WBUF_DEPTH); k++) begin
            logic [PtrW-1:0] slot;
            slot = head_q + PtrW'(k);
            if (entries_q[slot].valid && entries_q[slot].index == IndexMax'(rd_index_i)) begin
                for (int l = 0; l < 4; l++) begin
                    if (entries_q[slot].sel[l]) begin
                        hit_o[l]             = 1'b1;
                        fwd_data_o[l*8 +: 8] = entries_q[slot].data[l*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/data_ram.sv
// Data-side memory responder for the core's ram_* bus.
//   clk, rst     : clock, async active-low reset (array contents are not reset)
//   bus          : core bus (slave modport); reads answered combinationally
//   ld_we_i      : loader full-word write strobe, wins the array write port
//   ld_addr_i    : loader word index
//   ld_data_i    : loader write data
module data_ram
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WBUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_ram_if.slave             bus,
    input  logic                  ld_we_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [DataBus-1:0]    ld_data_i
);

    logic [DataBus-1:0]    mem_q [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] word_index;
    logic                  drain;
    logic [ADDR_WIDTH-1:0] drain_index;
    logic [3:0]            drain_sel;
    logic [DataBus-1:0]    drain_data;
    logic [3:0]            hit;
    logic [DataBus-1:0]    fwd_data;
    logic [DataBus-1:0]    array_word;
    logic                  unused_addr;

    // Upper address bits alias; byte offset is carried by sel.
    assign word_index  = bus.addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{bus.addr[DataAddrBus-1:ADDR_WIDTH+2], bus.addr[1:0]};

    data_ram_wbuf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WBUF_DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk           (clk),
        .rst           (rst),
        .push_req_i    (bus.ce & bus.we),
        .push_index_i  (word_index),
        .push_sel_i    (bus.sel),
        .push_data_i   (bus.wdata),
        .drain_block_i (ld_we_i),
        .drain_o       (drain),
        .drain_index_o (drain_index),
        .drain_sel_o   (drain_sel),
        .drain_data_o  (drain_data),
        .rd_index_i    (word_index),
        .hit_o         (hit),
        .fwd_data_o    (fwd_data),
        .stall_o       (bus.stall)
    );

    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            mem_q[ld_addr_i] <= ld_data_i;
        end else if (drain) begin
            for (int l = 0; l < 4; l++) begin
                if (drain_sel[l]) begin
                    mem_q[drain_index][l*8 +: 8] <= drain_data[l*8 +: 8];
                end
            end
        end
    end

    assign array_word = mem_q[word_index];

    always_comb begin
        bus.rdata = '0;
        if (bus.ce && !bus.we) begin
            for (int l = 0; l < 4; l++) begin
                bus.rdata[l*8 +: 8] = hit[l] ? fwd_data[l*8 +: 8] : array_word[l*8 +: 8];
            end
        end
    end

endmodule

// File: doc/data_ram.md
# data_ram

Data-side memory responder that answers the CPU core's `ram_*` interface: it accepts `ram_ce_o/we_o/addr_o/sel_o/data_o` and returns `ram_data_i`. Reads are answered combinationally in the same cycle, which the MEM stage requires. Writes are posted into a small write buffer and drained into a single-write-port word array. A full-word loader port, used for program/data initialisation, has priority on the array write port. The block sits in the SoC top beside the instruction ROM.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; array holds 2^ADDR_WIDTH 32-bit words.
- `WBUF_DEPTH`, 2: posted-write buffer entries; power of two, ≥2.

- `clk`  in  1  — system clock; all state changes on rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `ce_i`  in  1  — access enable from core (`ram_ce_o`).
- `we_i`  in  1  — 1 = write, 0 = read; ignored when `ce_i`=0.
- `addr_i`  in  32  — byte address; word index = `addr_i[ADDR_WIDTH+1:2]`; other bits ignored (aliasing).
- `sel_i`  in  4  — byte-lane enables; `sel_i[3]` selects `data[31:24]`.
- `data_i`  in  32  — write data.
- `data_o`  out  32  — read data to core (`ram_data_i`); combinational.
- `stall_o`  out  1  — registered; 1 when the write buffer is full. A core write presented while it is 1 is dropped.
- `ld_we_i`  in  1  — loader full-word write strobe.
- `ld_addr_i`  in  ADDR_WIDTH  — loader word index.
- `ld_data_i`  in  32  — loader write data.

## Operation
- **Read** (`ce_i`=1, `we_i`=0):
  - `data_o` is a full word regardless of `sel_i`.
  - Per byte lane, `data_o` takes the newest buffer entry whose word index matches and whose sel bit is set.
  - If no entry matches, the lane comes from the array.
- `ce_i`=0 or write cycle: `data_o` = 0.
- **Core write** (`ce_i`&`we_i`&!`stall_o`):
  - Entry {index, sel, data} is pushed at the rising edge.
  - `sel_i`=0 is pushed as a no-op entry.
- **Drain:** if the buffer is non-empty and `ld_we_i`=0, the head entry is written to the array at the edge, only for lanes with sel=1, then popped.
- **Loader write:** writes all 4 lanes at the edge and blocks the drain that cycle. Pending buffer entries to the same index later overwrite their lanes; the loader is for init only, with no coherence guarantee.
- **Simultaneous push+drain:** occupancy is unchanged.
- **Push while full:** the write is rejected even if a drain occurs that same cycle.
- **Occupancy:**
  - Head and tail pointers wrap modulo `WBUF_DEPTH`.
  - The count is `$clog2(WBUF_DEPTH)+1` bits.
  - `stall_o` <= (next count == `WBUF_DEPTH`).
- **Reset (`rst`=0):**
  - Pointers and count are 0; all entries are invalid; `stall_o`=0.
  - Array contents are not reset.
  - Reset mid-operation discards all pending writes.

## Timing
- Read latency is 0 cycles; buffer-forwarded data is visible in the cycle after the push edge.
- Write-to-array latency is ≥1 cycle after push. It is exactly 1 cycle when the buffer was empty and `ld_we_i`=0 on the following edge.
- `stall_o` rises the cycle after the push that fills the buffer and falls the cycle after the first drain from full.

## Structure
- Shared package `mem_pkg`:
  - `DataBus`/`DataAddrBus` widths.
  - Typedef `wbuf_entry_t` {index, sel[3:0], data[31:0], valid}.
  - Constant `SEL_WORD` = 4'b1111.
- Sub-module `data_ram_wbuf`:
  - FIFO storage, pointers, count, stall register.
  - Per-lane newest-match forwarding; outputs a 4-bit hit mask plus merged data.
- `data_ram` holds the array, write-port arbitration (loader > drain) and the final lane mux.

## Test plan
- **Loader then read:** loader writes 0xDEADBEEF to index 5; core reads 0x14 → `data_o`=0xDEADBEEF in the same cycle.
- **Partial write forwarding:** starting from 0xDEADBEEF, core writes sel=4'b0011, data 0x0000_1234 to 0x14; read the next cycle → 0xDEAD1234, both from the buffer and after drain.
- **Newest-wins:**
  - Stall drain with `ld_we_i`=1 to another index.
  - Push writes sel=0001 0xAA then sel=0001 0xBB to 0x20.
  - Read returns low byte 0xBB.
  - After the drain finishes, the array holds 0xBB.
- **Full/stall:**
  - Hold `ld_we_i`=1; push 2 writes → `stall_o`=1 the next cycle.
  - A third write is dropped: its data is never readable.
  - Release the loader → `stall_o`=0 one cycle after the first drain.
- **Mid-operation reset:** with 2 pending entries, assert `rst`=0 asynchronously → `stall_o`=0 immediately; subsequent reads return pre-write array data.
- **Aliasing/ce:**
  - Read 0x0000_1014 with `ADDR_WIDTH`=10 → returns index 5.
  - `ce_i`=0 → `data_o`=0.
